// File: rtl/led_pkg.sv
// Shared constants and types for the water-LED pattern generator and its PWM fade stage.
package led_pkg;

    localparam int LED_NUM = 8;

    typedef logic [LED_NUM-1:0] led_vec_t;

    localparam int PWM_BITS_DEF  = 8;
    localparam int FADE_DIV_DEF  = 78125;   // 3.125 ms fade tick at 25 MHz
    localparam int FADE_STEP_DEF = 8;

    // 32 fade ticks make one 100 ms pattern step, so the trail is one position long.
    localparam int STEP_DIV_100MS = 32 * FADE_DIV_DEF;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: fading brightness level, period-aligned shadow duty and PWM compare.
// Define LED_FADE_GAMMA_EN to map level to duty through a squaring (perceptual) curve.
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pat,
    input  logic                fade_tick,
    input  logic                load,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                raw
);

    localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_map;

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    // Full-on is special-cased so a lit LED stays constantly on.
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
        duty_map = (level == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign duty_map = level;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            duty  <= '0;
        end else begin
            // A lit bit always wins over a fade tick in the same cycle.
            if (pat) begin
                level <= MAX;
            end else if (fade_tick) begin
                level <= (level >= STEP) ? (level - STEP) : '0;
            end
            if (load) begin
                duty <= duty_map;
            end
        end
    end

    assign raw = (pwm_cnt < duty);

endmodule

// File: rtl/led_fade_pwm.sv
// Per-LED PWM driver with linear fade-out trail behind the upstream on/off pattern.
// Optional macro LED_FADE_GAMMA_EN selects the gamma-corrected duty mapping in each channel.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int FADE_DIV   = FADE_DIV_DEF,
    parameter int FADE_STEP  = FADE_STEP_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  led_vec_t pattern_in,
    output led_vec_t led_out,
    output logic     pwm_sync
);

    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FW-1:0]       FADE_LAST = FW'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

    led_vec_t            pat_q;
    led_vec_t            raw;
    logic [FW-1:0]       fade_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                fade_tick;
    logic                load;

    assign fade_tick = (fade_cnt == FADE_LAST);
    // Period is MAX clocks, so the shadow load happens on count MAX-1.
    assign load      = (pwm_cnt == PWM_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q    <= '0;
            fade_cnt <= '0;
            pwm_cnt  <= '0;
            led_out  <= {LED_NUM{ACTIVE_LOW}};
            pwm_sync <= 1'b0;
        end else begin
            pat_q    <= pattern_in;
            fade_cnt <= fade_tick ? '0 : fade_cnt + 1'b1;
            pwm_cnt  <= load ? '0 : pwm_cnt + 1'b1;
            led_out  <= raw ^ {LED_NUM{ACTIVE_LOW}};
            pwm_sync <= (pwm_cnt == '0);
        end
    end

    for (genvar i = 0; i < LED_NUM; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .pat       (pat_q[i]),
            .fade_tick (fade_tick),
            .load      (load),
            .pwm_cnt   (pwm_cnt),
            .raw       (raw[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: three instances with different fade/polarity settings.
module tb_led_fade_pwm;
    import led_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    led_vec_t pat_a, pat_b, pat_c;
    led_vec_t led_a, led_b, led_c;
    logic     sync_a, sync_b, sync_c;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    always #20 clk = ~clk;

    // a: fast fade; b: fade tick locked to the PWM period, active-low; c: step 1, locked.
    led_fade_pwm #(.FADE_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .pattern_in(pat_a), .led_out(led_a), .pwm_sync(sync_a)
    );
    led_fade_pwm #(.FADE_DIV(255), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .pattern_in(pat_b), .led_out(led_b), .pwm_sync(sync_b)
    );
    led_fade_pwm #(.FADE_DIV(255), .FADE_STEP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .pattern_in(pat_c), .led_out(led_c), .pwm_sync(sync_c)
    );

    function automatic int gam(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l == 255) ? 255 : ((l * l) >> 8);
`else
        return l;
`endif
    endfunction

    function logic sync_of(input int w);
        return (w == 0) ? sync_a : (w == 1) ? sync_b : sync_c;
    endfunction

    // Active-high view of the LED drive (instance b is sink-driven).
    function led_vec_t led_of(input int w);
        return (w == 0) ? led_a : (w == 1) ? ~led_b : led_c;
    endfunction

    task automatic wait_sync(input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (sync_of(w) === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL sync_timeout dut%0d: no pwm_sync within 300 cycles", w);
        end
    endtask

    task automatic measure_hi(input int w, input int b, output int hi);
        bit ok;
        led_vec_t l;
        hi = 0;
        wait_sync(w, ok);
        if (ok) begin
            for (int i = 0; i < 255; i++) begin
                if (i > 0) @(negedge clk);
                l = led_of(w);
                if (l[b] === 1'b1) hi++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pat_a = 8'hFF; pat_b = 8'hFF; pat_c = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (led_a !== 8'h00) begin err_cnt++; $display("FAIL reset_led_a got %h exp 00", led_a); end
        vec_cnt++; if (sync_a !== 1'b0) begin err_cnt++; $display("FAIL reset_sync_a got %b exp 0", sync_a); end
        vec_cnt++; if (led_b !== 8'hFF) begin err_cnt++; $display("FAIL reset_led_b_active_low got %h exp ff", led_b); end
        vec_cnt++; if (sync_b !== 1'b0) begin err_cnt++; $display("FAIL reset_sync_b got %b exp 0", sync_b); end
        vec_cnt++; if (led_c !== 8'h00) begin err_cnt++; $display("FAIL reset_led_c got %h exp 00", led_c); end
        pat_a = 8'hA5; pat_b = 8'h01; pat_c = 8'h01;
        rst_n = 1'b1;
    endtask

    task automatic test_full_on;
        bit ok;
        int bad = 0;
        int sync_bad = 0;
        wait_sync(0, ok);
        wait_sync(0, ok);
        for (int i = 0; i < 510; i++) begin
            if (i > 0) @(negedge clk);
            if (led_a !== 8'hA5) bad++;
            if (sync_a !== ((i % 255) == 0)) sync_bad++;
        end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL full_on_led got %0d bad cycles exp 0", bad); end
        vec_cnt++; if (sync_bad != 0) begin err_cnt++; $display("FAIL full_on_sync_period got %0d bad cycles exp 0", sync_bad); end
    endtask

    task automatic test_fade;
        bit ok;
        int hi;
        logic [7:0] exp;
        for (int j = 1; j <= 34; j++) exp_q.push_back((j <= 32) ? 8'(gam(255 - 8 * (j - 1))) : 8'd0);
        wait_sync(1, ok);
        pat_b = 8'h00;
        for (int j = 1; j <= 34; j++) begin
            measure_hi(1, 0, hi);
            exp = exp_q.pop_front();
            vec_cnt++;
            if (hi !== int'(exp)) begin
                err_cnt++;
                $display("FAIL fade_period%0d high_time got %0d exp %0d", j, hi, exp);
            end
        end
    endtask

    task automatic test_collision;
        bit ok;
        int hi;
        wait_sync(1, ok);
        repeat (252) @(negedge clk);
        pat_b = 8'h08;      // captured into pat_q on the tick/load cycle
        @(negedge clk);
        pat_b = 8'h00;
        measure_hi(1, 3, hi);
        vec_cnt++; if (hi !== 0) begin err_cnt++; $display("FAIL collision_p1 got %0d exp 0", hi); end
        measure_hi(1, 3, hi);
        vec_cnt++; if (hi !== 255) begin err_cnt++; $display("FAIL collision_level got %0d exp 255", hi); end
        measure_hi(1, 3, hi);
        vec_cnt++; if (hi !== gam(247)) begin err_cnt++; $display("FAIL collision_p3 got %0d exp %0d", hi, gam(247)); end
    endtask

    task automatic test_mid_duty;
        bit ok;
        int hi = 0;
        int bad = 0;
        int exp_hi;
        exp_hi = gam(128);
        wait_sync(2, ok);
        pat_c = 8'h00;
        for (int j = 1; j <= 127; j++) wait_sync(2, ok);
        wait_sync(2, ok);
        for (int i = 0; i < 255; i++) begin
            if (i > 0) @(negedge clk);
            if (led_c[0] === 1'b1) hi++;
            if (led_c[0] !== (i < exp_hi)) bad++;
        end
        vec_cnt++; if (hi != exp_hi) begin err_cnt++; $display("FAIL mid_duty_high got %0d exp %0d", hi, exp_hi); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL mid_duty_contiguous got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_reset_mid_fade;
        int bad_a = 0;
        int bad_c = 0;
        pat_a = 8'h01; pat_c = 8'h01;
        repeat (10) @(negedge clk);
        pat_a = 8'h00; pat_c = 8'h00;
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vec_cnt++; if (led_a !== 8'h00) begin err_cnt++; $display("FAIL midreset_led_a got %h exp 00", led_a); end
        vec_cnt++; if (sync_a !== 1'b0) begin err_cnt++; $display("FAIL midreset_sync_a got %b exp 0", sync_a); end
        vec_cnt++; if (led_b !== 8'hFF) begin err_cnt++; $display("FAIL midreset_led_b got %h exp ff", led_b); end
        vec_cnt++; if (led_c !== 8'h00) begin err_cnt++; $display("FAIL midreset_led_c got %h exp 00", led_c); end
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++; if (sync_a !== 1'b1) begin err_cnt++; $display("FAIL midreset_first_sync got %b exp 1", sync_a); end
        for (int i = 0; i < 510; i++) begin
            if (i > 0) @(negedge clk);
            if (led_a !== 8'h00) bad_a++;
            if (led_c !== 8'h00) bad_c++;
        end
        vec_cnt++; if (bad_a != 0) begin err_cnt++; $display("FAIL midreset_trail_a got %0d lit cycles exp 0", bad_a); end
        vec_cnt++; if (bad_c != 0) begin err_cnt++; $display("FAIL midreset_trail_c got %0d lit cycles exp 0", bad_c); end
    endtask

    initial begin
        test_reset();
        test_full_on();
        test_fade();
        test_collision();
        test_mid_duty();
        test_reset_mid_fade();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
